// File: rtl/stdin_word_buffer.sv
// Host byte stream -> 16-bit TOY words -> FWFT FIFO -> valid/ready to the core.
// Optional STDIN_HEX_ASCII_EN: assemble words from four ASCII hex digits instead of two raw bytes.
module stdin_word_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             byte_val_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_rdy_o,
  input  logic             flush_i,
  output logic             out_val_o,
  output logic [15:0]      out_data_o,
  input  logic             out_rdy_i,
  output logic [CNT_W-1:0] level_o,
  output logic             partial_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] level;
  logic             clr, byte_fire, push, pop;
  logic [15:0]      push_data;

  assign clr        = rst_i | flush_i;
  // Full test on the registered level: a completing byte always has a free slot.
  assign byte_rdy_o = (level != FULL);
  assign out_val_o  = (level != '0);
  assign level_o    = level;
  assign byte_fire  = byte_val_i & byte_rdy_o & ~clr;
  assign pop        = out_val_o & out_rdy_i & ~clr;

`ifdef STDIN_HEX_ASCII_EN
  logic [1:0]  dcnt;
  logic [11:0] acc;
  logic        is_hex;
  logic [3:0]  nib;

  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    if (byte_data_i >= 8'h30 && byte_data_i <= 8'h39)      nib = 4'(byte_data_i - 8'h30);
    else if (byte_data_i >= 8'h61 && byte_data_i <= 8'h66) nib = 4'(byte_data_i - 8'h57);
    else if (byte_data_i >= 8'h41 && byte_data_i <= 8'h46) nib = 4'(byte_data_i - 8'h37);
    else                                                   is_hex = 1'b0;
  end

  // Any separator resets the digit count, so a short run never leaks into the next word.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      dcnt <= 2'd0;
      acc  <= 12'h000;
    end else if (byte_fire) begin
      if (!is_hex) begin
        dcnt <= 2'd0;
      end else begin
        dcnt <= dcnt + 2'd1;
        acc  <= {acc[7:0], nib};
      end
    end
  end

  assign push      = byte_fire & is_hex & (dcnt == 2'd3);
  assign push_data = {acc, nib};
  assign partial_o = (dcnt != 2'd0);
`else
  logic       have_hi;
  logic [7:0] hi_byte;

  always_ff @(posedge clk_i) begin
    if (clr) begin
      have_hi <= 1'b0;
      hi_byte <= 8'h00;
    end else if (byte_fire) begin
      have_hi <= ~have_hi;
      if (!have_hi) hi_byte <= byte_data_i;
    end
  end

  assign push      = byte_fire & have_hi;
  assign push_data = {hi_byte, byte_data_i};
  assign partial_o = have_hi;
`endif

  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign out_data_o = out_val_o ? mem[rd_ptr] : 16'h0000;
endmodule

// File: tb/tb_stdin_word_buffer.sv
// Randomized + directed bench for stdin_word_buffer against a queue-based word model.
module tb_stdin_word_buffer;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH+1);
`ifdef STDIN_HEX_ASCII_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic             clk = 1'b0, rst = 1'b1, byte_val = 1'b0, flush = 1'b0, out_rdy = 1'b0;
  logic [7:0]       byte_data = 8'h00;
  logic             byte_rdy, out_val, partial;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] level;

  stdin_word_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .byte_val_i(byte_val), .byte_data_i(byte_data),
    .byte_rdy_o(byte_rdy), .flush_i(flush), .out_val_o(out_val), .out_data_o(out_data),
    .out_rdy_i(out_rdy), .level_o(level), .partial_o(partial)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, max_lvl = 0;
  bit started = 1'b0;
  int q[$];        // words stored, head first
  int pend[$];     // bytes / digits of the word being assembled
  logic [7:0] bq[$];
  bit m_pop, m_take;
  int m_v, exp_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    return -1;
  endfunction

  function automatic logic [7:0] hexchar(input logic [3:0] n, input bit up);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (up ? 8'h41 : 8'h61) + 8'(n) - 8'd10;
  endfunction

  // Reference model: a word queue plus a list of pending bytes/digits.
  always @(posedge clk) begin
    if (rst || flush) begin
      q.delete();
      pend.delete();
    end else begin
      m_pop  = (q.size() != 0) && out_rdy;
      m_take = byte_val && (q.size() != DEPTH);
      if (m_pop) void'(q.pop_front());
      if (m_take) begin
        if (!HEX) begin
          pend.push_back(int'(byte_data));
          if (pend.size() == 2) begin
            q.push_back(pend[0] * 256 + pend[1]);
            pend.delete();
          end
        end else begin
          m_v = hexval(byte_data);
          if (m_v < 0) pend.delete();
          else begin
            pend.push_back(m_v);
            if (pend.size() == 4) begin
              q.push_back(pend[0] * 4096 + pend[1] * 256 + pend[2] * 16 + pend[3]);
              pend.delete();
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      exp_data = (q.size() != 0) ? q[0] : 0;
      chk("out_val", 32'(out_val), 32'(q.size() != 0));
      chk("out_data", 32'(out_data), exp_data);
      chk("level", 32'(level), q.size());
      chk("partial", 32'(partial), 32'(pend.size() != 0));
      chk("byte_rdy", 32'(byte_rdy), 32'(q.size() != DEPTH));
      chk("level_bound", 32'(int'(level) <= DEPTH), 32'd1);
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_val = 1'b1; byte_data = b;
    for (int i = 0; i < 200; i++) begin
      ok = byte_rdy;
      @(negedge clk);
      if (ok) break;
    end
    byte_val = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic encode(input logic [15:0] w);
    bq.delete();
    if (!HEX) begin
      bq.push_back(w[15:8]); bq.push_back(w[7:0]);
    end else begin
      for (int k = 3; k >= 0; k--) bq.push_back(hexchar(w[4*k +: 4], bit'($urandom % 2)));
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    encode(w);
    foreach (bq[i]) send_byte(bq[i]);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain();
    out_rdy = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    out_rdy = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("T1 out_val", 32'(out_val), 32'd0);
    chk("T1 level", 32'(level), 32'd0);
    chk("T1 partial", 32'(partial), 32'd0);
    chk("T1 byte_rdy", 32'(byte_rdy), 32'd1);
    chk("T1 out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // T2
    send_word(16'h8A01);
    chk("T2 out_val", 32'(out_val), 32'd1);
    chk("T2 out_data", 32'(out_data), 32'h8A01);
    chk("T2 level", 32'(level), 32'd1);
    drain();

    // T3: fill across pointer wrap, pop once, refill, drain in order
    for (int i = 0; i < DEPTH; i++) send_word(16'hA000 + 16'(i));
    chk("T3 level_full", 32'(level), DEPTH);
    chk("T3 byte_rdy_full", 32'(byte_rdy), 32'd0);
    chk("T3 head", 32'(out_data), 32'hA000);
    out_rdy = 1'b1; @(negedge clk); out_rdy = 1'b0;
    chk("T3 byte_rdy_after_pop", 32'(byte_rdy), 32'd1);
    chk("T3 head_after_pop", 32'(out_data), 32'hA001);
    send_word(16'hB000);
    out_rdy = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      chk("T3 order", 32'(out_data), 32'hA000 + i);
      @(negedge clk);
    end
    chk("T3 wrap_tail", 32'(out_data), 32'hB000);
    @(negedge clk);
    out_rdy = 1'b0;
    chk("T3 empty", 32'(level), 32'd0);

    // T4: streaming with the core always ready
    max_lvl = 0;
    out_rdy = 1'b1;
    for (int i = 0; i < 256; i++) send_word(16'(i));
    @(negedge clk);
    chk("T4 max_level", 32'(max_lvl <= 1), 32'd1);
    out_rdy = 1'b0;
    // push and pop in the same cycle
    send_word(16'h1111);
    encode(16'h2233);
    for (int i = 0; i < bq.size() - 1; i++) send_byte(bq[i]);
    byte_val = 1'b1; byte_data = bq[bq.size()-1]; out_rdy = 1'b1;
    @(negedge clk);
    byte_val = 1'b0; out_rdy = 1'b0;
    chk("T4 pushpop_level", 32'(level), 32'd1);
    chk("T4 pushpop_data", 32'(out_data), 32'h2233);
    drain();

    // T5: flush mid-word
    encode(16'h1234);
    send_byte(bq[0]);
    chk("T5 partial_set", 32'(partial), 32'd1);
    flush = 1'b1; byte_val = 1'b1; byte_data = bq[1];
    @(negedge clk);
    flush = 1'b0; byte_val = 1'b0;
    chk("T5 partial_clr", 32'(partial), 32'd0);
    chk("T5 level_clr", 32'(level), 32'd0);
    send_word(16'h3456);
    chk("T5 word", 32'(out_data), 32'h3456);
    chk("T5 level", 32'(level), 32'd1);
    drain();

`ifdef STDIN_HEX_ASCII_EN
    send_str("7F0A\n1b");
    chk("T6 partial", 32'(partial), 32'd1);
    send_str("c2");
    chk("T6 level2", 32'(level), 32'd2);
    chk("T6 first", 32'(out_data), 32'h7F0A);
    out_rdy = 1'b1; @(negedge clk); out_rdy = 1'b0;
    chk("T6 second", 32'(out_data), 32'h1BC2);
    drain();
    send_str("12 ");
    chk("T6 dropped_partial", 32'(partial), 32'd0);
    send_str("3456");
    chk("T6 only_word", 32'(out_data), 32'h3456);
    chk("T6 only_level", 32'(level), 32'd1);
    drain();
`endif

    // Random traffic, including flush/reset colliding with bytes and pops
    for (int c = 0; c < 3000; c++) begin
      byte_val = ($urandom % 4) != 0;
      if (HEX && ($urandom % 5) != 0) byte_data = hexchar(4'($urandom), bit'($urandom % 2));
      else                            byte_data = 8'($urandom);
      out_rdy = (c < 1500) ? (($urandom % 6) == 0) : (($urandom % 2) == 0);
      flush   = ($urandom % 120) == 0;
      rst     = ($urandom % 400) == 0;
      @(negedge clk);
    end
    byte_val = 1'b0; flush = 1'b0; rst = 1'b0;
    drain();
    chk("final_empty", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
